pre_mem_writer: RTL and testbench
=================================

PRE_MEM_WRITER -- requirements
Module: pre_mem_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: write-buffer depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter CMD_WR, default 4'h1: PRE_CMD code for a burst write.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PRE_WR_BUF  input  1  push strobe; PRE_DIN enters the buffer this cycle.
REQ-006 SHALL have port PRE_DIN  input  32  pooled/encoded data word.
REQ-007 SHALL have port PRE_REQ  input  1  burst request level from the pooling stage.
REQ-008 SHALL have port PRE_CMD  input  4  command, sampled with the request.
REQ-009 SHALL have port PRE_ADDR  input  32  burst start byte address, word-aligned; sampled with the request.
REQ-010 SHALL have port MEM_PRE_SEL  output  1  writer owns the memory port (busy).
REQ-011 SHALL have port MEM_FIN  output  1  one-cycle burst-complete pulse.
REQ-012 SHALL have port SRAM_GNT  input  1  arbiter grant; a write completes only when high.
REQ-013 SHALL have port SRAM_CS  output  1  SRAM access strobe.
REQ-014 SHALL have port SRAM_WE  output  1  write enable, equal to SRAM_CS.
REQ-015 SHALL have port SRAM_ADDR  output  32  SRAM byte address.
REQ-016 SHALL have port SRAM_WDATA  output  32  SRAM write data.
REQ-017 SHALL have port BUF_CNT  output  $clog2(DEPTH)+1  current buffer occupancy.
REQ-018 SHALL have port ERR  output  2  sticky flags: bit0 buffer overflow, bit1 illegal command.

Function
REQ-019 SHALL implement the buffer as a show-ahead FIFO; the head word drives SRAM_WDATA combinationally.
REQ-020 SHALL push on PRE_WR_BUF when not full; a push while full SHALL be dropped and set ERR[0].
REQ-021 SHALL allow a push and a pop in the same cycle, including when full (the pop frees space first, so the push is accepted) or when count==1.
REQ-022 SHALL detect a request only on a PRE_REQ rising edge (PRE_REQ high, previous-cycle value low) while in IDLE; edges outside IDLE SHALL be ignored.
REQ-023 SHALL use states IDLE, DRAIN, FIN.
REQ-024 SHALL, on an accepted request with PRE_CMD==CMD_WR, latch the address into addr_q and the current BUF_CNT into rem_q, then enter DRAIN.
REQ-025 SHALL, on an accepted request with any other PRE_CMD, set ERR[1] and enter FIN with no SRAM access.
REQ-026 SHALL hold MEM_PRE_SEL high in DRAIN and FIN, and low in IDLE.
REQ-027 SHALL, in DRAIN with rem_q>0, drive SRAM_CS=SRAM_WE=1, SRAM_ADDR=addr_q and SRAM_WDATA=FIFO head.
REQ-028 SHALL, on an edge with SRAM_CS&SRAM_GNT, pop the FIFO, decrement rem_q and add 4 to addr_q (modulo 2^32).
REQ-029 SHALL hold all state and outputs unchanged while SRAM_GNT is low.
REQ-030 SHALL go DRAIN->FIN in the cycle rem_q is 0; a zero-length burst therefore spends one cycle in DRAIN with SRAM_CS low.
REQ-031 SHALL keep words pushed during DRAIN in the buffer for the next burst, not add them to rem_q.
REQ-032 SHALL assert MEM_FIN for exactly the one FIN cycle, then return to IDLE.
REQ-033 SHALL drive SRAM_CS low and SRAM_ADDR/SRAM_WDATA to 0 outside DRAIN.

Reset
REQ-034 SHALL, while rst_n is low, force IDLE, empty FIFO, BUF_CNT=0, ERR=0, addr_q=0, rem_q=0, request-edge register=0, and all outputs 0.
REQ-035 SHALL, on reset mid-burst, abandon the burst with no MEM_FIN pulse and discard the buffered data.

Verification
REQ-036 SHALL pass: push 4 words A0..A3; rising PRE_REQ with CMD=1, ADDR=0x100; SRAM_GNT=1 -> writes 0x100/A0, 0x104/A1, 0x108/A2, 0x10C/A3 on consecutive cycles, then one MEM_FIN pulse, BUF_CNT=0.
REQ-037 SHALL pass: same burst with SRAM_GNT low for 3 cycles after the second write -> SRAM_ADDR held at 0x108 for those cycles, no lost or duplicated word, total 4 writes.
REQ-038 SHALL pass: 17 pushes with no drain -> BUF_CNT=16, ERR=2'b01, and a later burst writes the first 16 words only.
REQ-039 SHALL pass: push 2 words, request, push 3 more during DRAIN -> burst writes 2 words, BUF_CNT=3 after MEM_FIN; PRE_REQ held high through FIN starts no second burst.
REQ-040 SHALL pass: request with CMD=4'h7 -> no SRAM_CS, MEM_FIN one cycle later, ERR[1]=1; request with an empty buffer -> MEM_FIN with zero writes.
REQ-041 SHALL pass: rst_n low during the third write of an 8-word burst -> all outputs 0 immediately, no MEM_FIN, BUF_CNT=0 after release.

Source files
------------

// File: rtl/pre_mem_writer_if.sv
// Pooling-stage / SRAM-side signal bundle for pre_mem_writer.
// The writer takes the master modport; the environment takes the slave modport.
interface pre_mem_writer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          PRE_WR_BUF;
  logic [31:0]   PRE_DIN;
  logic          PRE_REQ;
  logic [3:0]    PRE_CMD;
  logic [31:0]   PRE_ADDR;
  logic          MEM_PRE_SEL;
  logic          MEM_FIN;
  logic          SRAM_GNT;
  logic          SRAM_CS;
  logic          SRAM_WE;
  logic [31:0]   SRAM_ADDR;
  logic [31:0]   SRAM_WDATA;
  logic [CW-1:0] BUF_CNT;
  logic [1:0]    ERR;

  modport master (
    input  PRE_WR_BUF, PRE_DIN, PRE_REQ, PRE_CMD, PRE_ADDR, SRAM_GNT,
    output MEM_PRE_SEL, MEM_FIN, SRAM_CS, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
           BUF_CNT, ERR
  );

  modport slave (
    output PRE_WR_BUF, PRE_DIN, PRE_REQ, PRE_CMD, PRE_ADDR, SRAM_GNT,
    input  MEM_PRE_SEL, MEM_FIN, SRAM_CS, SRAM_WE, SRAM_ADDR, SRAM_WDATA,
           BUF_CNT, ERR
  );
endinterface

// File: rtl/pre_mem_writer.sv
// Buffers pooled words in a show-ahead FIFO and drains them to SRAM as an
// address-incrementing burst when the pooling stage raises a write request.
module pre_mem_writer #(
  parameter int         DEPTH  = 16,
  parameter logic [3:0] CMD_WR = 4'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  pre_mem_writer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // state | meaning
  // IDLE  | waiting for a PRE_REQ rising edge
  // DRAIN | writing rem_q buffered words to SRAM
  // FIN   | one-cycle MEM_FIN pulse
  typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   addr_q;
  logic [CW-1:0] rem_q;
  logic          req_q;
  logic [1:0]    err_q;

  logic full, pop, push, overflow, req_edge;
  logic ld, cmd_err, sram_cs, fin;

  assign full     = (count == CW'(DEPTH));
  assign pop      = sram_cs & bus.SRAM_GNT;
  // A same-cycle pop frees a slot, so a push into a full buffer still lands.
  assign push     = bus.PRE_WR_BUF & (~full | pop);
  assign overflow = bus.PRE_WR_BUF & ~push;
  assign req_edge = bus.PRE_REQ & ~req_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.PRE_DIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      req_q  <= 1'b0;
      err_q  <= '0;
    end else begin
      state <= state_nxt;
      req_q <= bus.PRE_REQ;
      err_q <= err_q | {cmd_err, overflow};
      // Burst length is frozen at request time; later pushes wait for the next burst.
      if (ld) begin
        addr_q <= bus.PRE_ADDR;
        rem_q  <= count;
      end else if (pop) begin
        addr_q <= addr_q + 32'd4;
        rem_q  <= rem_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    cmd_err   = 1'b0;
    sram_cs   = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge) begin
          if (bus.PRE_CMD == CMD_WR) begin
            ld        = 1'b1;
            state_nxt = DRAIN;
          end else begin
            cmd_err   = 1'b1;
            state_nxt = FIN;
          end
        end
      end
      DRAIN: begin
        if (rem_q == '0) state_nxt = FIN;
        else             sram_cs   = 1'b1;
      end
      FIN: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.MEM_PRE_SEL = (state != IDLE);
  assign bus.MEM_FIN     = fin;
  assign bus.SRAM_CS     = sram_cs;
  assign bus.SRAM_WE     = sram_cs;
  assign bus.SRAM_ADDR   = sram_cs ? addr_q : 32'd0;
  assign bus.SRAM_WDATA  = sram_cs ? mem[rd_ptr] : 32'd0;
  assign bus.BUF_CNT     = count;
  assign bus.ERR         = err_q;
endmodule

// File: tb/tb_pre_mem_writer.sv
// Scoreboard bench for pre_mem_writer: expected {addr,data} pairs are queued
// when a burst is requested and retired as the writer completes SRAM writes.
module tb_pre_mem_writer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pre_mem_writer_if #(.DEPTH(16)) bus();
  pre_mem_writer #(.DEPTH(16), .CMD_WR(4'h1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_q[$];
  logic [63:0] exp_q[$];
  int wr_cnt = 0, fin_cnt = 0, cs_cnt = 0, cyc = 0;
  int first_wr = -1, last_wr = -1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      logic [63:0] e;
      if (bus.SRAM_CS) cs_cnt++;
      if (bus.SRAM_WE !== bus.SRAM_CS) chk("we_eq_cs", 32'(bus.SRAM_WE), 32'(bus.SRAM_CS));
      if (bus.SRAM_CS && bus.SRAM_GNT) begin
        chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.SRAM_ADDR, e[63:32]);
          chk("wr_data", bus.SRAM_WDATA, e[31:0]);
        end
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (bus.MEM_FIN) fin_cnt++;
    end
  end

  task automatic push_word(logic [31:0] d);
    bus.PRE_WR_BUF = 1'b1;
    bus.PRE_DIN    = d;
    if (model_q.size() + exp_q.size() < 16) model_q.push_back(d);
    @(posedge clk); #1;
    bus.PRE_WR_BUF = 1'b0;
  endtask

  task automatic request(logic [3:0] cmd, logic [31:0] a);
    bus.PRE_REQ  = 1'b1;
    bus.PRE_CMD  = cmd;
    bus.PRE_ADDR = a;
    if (cmd == 4'h1) begin
      while (model_q.size() > 0) begin
        exp_q.push_back({a, model_q.pop_front()});
        a += 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_fin(int base, string tag);
    int g = 0;
    while (fin_cnt == base && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk({tag, "_fin_seen"}, fin_cnt, base + 1);
  endtask

  task automatic wait_writes(int target, string tag);
    int g = 0;
    while (wr_cnt < target && g < 50) begin
      @(posedge clk);
      g++;
    end
    chk({tag, "_writes_reached"}, wr_cnt, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.PRE_WR_BUF = 1'b0;
    bus.PRE_REQ    = 1'b0;
    bus.SRAM_GNT   = 1'b1;
    model_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, fb, cb;
    bus.PRE_WR_BUF = 1'b0;
    bus.PRE_DIN    = '0;
    bus.PRE_REQ    = 1'b0;
    bus.PRE_CMD    = '0;
    bus.PRE_ADDR   = '0;
    bus.SRAM_GNT   = 1'b1;

    // Reset state
    #12;
    chk("rst_sel",   32'(bus.MEM_PRE_SEL), 32'd0);
    chk("rst_fin",   32'(bus.MEM_FIN), 32'd0);
    chk("rst_cs",    32'(bus.SRAM_CS), 32'd0);
    chk("rst_addr",  bus.SRAM_ADDR, 32'd0);
    chk("rst_wdata", bus.SRAM_WDATA, 32'd0);
    chk("rst_cnt",   32'(bus.BUF_CNT), 32'd0);
    chk("rst_err",   32'(bus.ERR), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word burst
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    chk("t1_cnt_loaded", 32'(bus.BUF_CNT), 32'd4);
    wb = wr_cnt; fb = fin_cnt; first_wr = -1;
    request(4'h1, 32'h100);
    bus.PRE_REQ = 1'b0;
    wait_fin(fb, "t1");
    chk("t1_writes", wr_cnt - wb, 32'd4);
    chk("t1_consecutive", last_wr - first_wr, 32'd3);
    chk("t1_sb_empty", exp_q.size(), 32'd0);
    chk("t1_cnt_after", 32'(bus.BUF_CNT), 32'd0);
    @(negedge clk);
    chk("t1_fin_one_cycle", 32'(bus.MEM_FIN), 32'd0);
    chk("t1_sel_idle", 32'(bus.MEM_PRE_SEL), 32'd0);
    @(posedge clk); #1;

    // Grant withheld for 3 cycles after the second write
    for (int i = 0; i < 4; i++) push_word(32'hB000_0000 + 32'(i));
    wb = wr_cnt; fb = fin_cnt;
    request(4'h1, 32'h100);
    bus.PRE_REQ = 1'b0;
    wait_writes(wb + 2, "t2");
    #1 bus.SRAM_GNT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_addr_held", bus.SRAM_ADDR, 32'h108);
      chk("t2_cs_held", 32'(bus.SRAM_CS), 32'd1);
    end
    @(posedge clk); #1 bus.SRAM_GNT = 1'b1;
    wait_fin(fb, "t2");
    chk("t2_writes", wr_cnt - wb, 32'd4);
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // Overflow: 17 pushes into a 16-deep buffer
    do_reset();
    for (int i = 0; i < 17; i++) push_word(32'hC000_0000 + 32'(i));
    chk("t3_cnt_full", 32'(bus.BUF_CNT), 32'd16);
    chk("t3_err_ovf", 32'(bus.ERR), 32'd1);
    wb = wr_cnt; fb = fin_cnt;
    request(4'h1, 32'h0);
    bus.PRE_REQ = 1'b0;
    wait_fin(fb, "t3");
    chk("t3_writes", wr_cnt - wb, 32'd16);
    chk("t3_sb_empty", exp_q.size(), 32'd0);
    chk("t3_cnt_after", 32'(bus.BUF_CNT), 32'd0);

    // Pushes during DRAIN stay buffered; held PRE_REQ starts no new burst
    do_reset();
    push_word(32'hD000_0000);
    push_word(32'hD000_0001);
    wb = wr_cnt; fb = fin_cnt;
    request(4'h1, 32'h200);
    for (int i = 0; i < 3; i++) push_word(32'hE000_0000 + 32'(i));
    wait_fin(fb, "t4");
    repeat (5) @(posedge clk);
    #1;
    chk("t4_single_fin", fin_cnt, fb + 1);
    chk("t4_writes", wr_cnt - wb, 32'd2);
    chk("t4_cnt_left", 32'(bus.BUF_CNT), 32'd3);
    chk("t4_sel_idle", 32'(bus.MEM_PRE_SEL), 32'd0);
    bus.PRE_REQ = 1'b0;

    // Illegal command, then an empty-buffer burst
    do_reset();
    cb = cs_cnt; fb = fin_cnt; wb = wr_cnt;
    request(4'h7, 32'h300);
    bus.PRE_REQ = 1'b0;
    @(negedge clk);
    chk("t5_fin_next", 32'(bus.MEM_FIN), 32'd1);
    chk("t5_err_cmd", 32'(bus.ERR), 32'd2);
    @(posedge clk); #1;
    request(4'h1, 32'h400);
    bus.PRE_REQ = 1'b0;
    wait_fin(fb + 1, "t5");
    chk("t5_no_cs", cs_cnt, cb);
    chk("t5_no_writes", wr_cnt, wb);
    chk("t5_err_kept", 32'(bus.ERR), 32'd2);

    // Reset during the third write of an 8-word burst
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'hF000_0000 + 32'(i));
    wb = wr_cnt; fb = fin_cnt;
    request(4'h1, 32'h500);
    bus.PRE_REQ = 1'b0;
    wait_writes(wb + 2, "t6");
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cs_zero",   32'(bus.SRAM_CS), 32'd0);
    chk("t6_sel_zero",  32'(bus.MEM_PRE_SEL), 32'd0);
    chk("t6_addr_zero", bus.SRAM_ADDR, 32'd0);
    chk("t6_data_zero", bus.SRAM_WDATA, 32'd0);
    chk("t6_cnt_zero",  32'(bus.BUF_CNT), 32'd0);
    chk("t6_fin_zero",  32'(bus.MEM_FIN), 32'd0);
    exp_q.delete();
    model_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_fin", fin_cnt, fb);
    chk("t6_no_more_writes", wr_cnt - wb, 32'd2);
    chk("t6_cnt_after", 32'(bus.BUF_CNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
